// File: rtl/arq_rx_gbn.sv
// Go-back-N ARQ receiver: in-order delivery through a single output register, cumulative acks with idle refresh.
// Optional statistics counters are enabled by defining ARQ_RX_STATS_EN.
module arq_rx_gbn #(
   parameter int SEQ_W       = 3,
   parameter int DATA_W      = 32,
   parameter int ACK_REFRESH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SEQ_W-1:0]  in_seq,
   input  logic [DATA_W-1:0] in_data,
   input  logic              input_error,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              ack_valid,
   input  logic              ack_ready,
   output logic [SEQ_W-1:0]  ack_seq,
   output logic [15:0]       stat_err,
   output logic [15:0]       stat_dup,
   output logic [15:0]       stat_dlv
);

   localparam int RW = (ACK_REFRESH > 2) ? $clog2(ACK_REFRESH) : 1;
   localparam logic [RW-1:0] REF_LAST = (ACK_REFRESH > 0) ? RW'(ACK_REFRESH - 1) : '0;

   logic [SEQ_W-1:0]  expected_q, expected_d;
   logic [SEQ_W-1:0]  ack_seq_q, ack_seq_d;
   logic              ack_valid_q, ack_valid_d;
   logic              got_any_q, got_any_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [RW-1:0]     refresh_cnt_q, refresh_cnt_d;

   logic accept, is_err, in_order, mismatch, ack_event, refresh_fire;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign is_err    = accept && input_error;
   assign in_order  = accept && !input_error && (in_seq == expected_q);
   assign mismatch  = accept && !input_error && (in_seq != expected_q);
   // A mismatch re-acks only once something has been delivered; before that there is nothing to ack.
   assign ack_event = in_order || (mismatch && got_any_q);

   always_comb begin
      expected_d = expected_q;
      got_any_d  = got_any_q;
      if (in_order) begin
         expected_d = expected_q + 1'b1;
         got_any_d  = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (out_ready) out_valid_d = 1'b0;
      if (in_order) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data;
      end
   end

   always_comb begin
      refresh_fire  = 1'b0;
      refresh_cnt_d = refresh_cnt_q;
      if (ACK_REFRESH > 0) begin
         if (ack_event || ack_valid_q || !got_any_q) begin
            refresh_cnt_d = '0;
         end else if (refresh_cnt_q == REF_LAST) begin
            refresh_cnt_d = '0;
            refresh_fire  = 1'b1;
         end else begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
         end
      end
   end

   // Set wins over the handshake clear so a newer ack coalesces into the pending one.
   always_comb begin
      ack_valid_d = ack_valid_q;
      ack_seq_d   = ack_seq_q;
      if (ack_valid_q && ack_ready) ack_valid_d = 1'b0;
      if (ack_event || refresh_fire) ack_valid_d = 1'b1;
      if (in_order) ack_seq_d = in_seq;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         expected_q    <= '0;
         ack_seq_q     <= '1;
         ack_valid_q   <= 1'b0;
         got_any_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         refresh_cnt_q <= '0;
      end else begin
         expected_q    <= expected_d;
         ack_seq_q     <= ack_seq_d;
         ack_valid_q   <= ack_valid_d;
         got_any_q     <= got_any_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         refresh_cnt_q <= refresh_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign ack_valid = ack_valid_q;
   assign ack_seq   = ack_seq_q;

`ifdef ARQ_RX_STATS_EN
   logic [15:0] stat_err_q, stat_err_d;
   logic [15:0] stat_dup_q, stat_dup_d;
   logic [15:0] stat_dlv_q, stat_dlv_d;

   always_comb begin
      stat_err_d = stat_err_q;
      stat_dup_d = stat_dup_q;
      stat_dlv_d = stat_dlv_q;
      if (is_err && stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      if (mismatch && stat_dup_q != 16'hFFFF) stat_dup_d = stat_dup_q + 16'd1;
      if (out_valid_q && out_ready && stat_dlv_q != 16'hFFFF) stat_dlv_d = stat_dlv_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_err_q <= '0;
         stat_dup_q <= '0;
         stat_dlv_q <= '0;
      end else begin
         stat_err_q <= stat_err_d;
         stat_dup_q <= stat_dup_d;
         stat_dlv_q <= stat_dlv_d;
      end
   end

   assign stat_err = stat_err_q;
   assign stat_dup = stat_dup_q;
   assign stat_dlv = stat_dlv_q;
`else
   assign stat_err = '0;
   assign stat_dup = '0;
   assign stat_dlv = '0;
`endif

endmodule

// File: tb/tb_arq_rx_gbn.sv
// Directed self-checking bench for arq_rx_gbn (SEQ_W=3, DATA_W=32, ACK_REFRESH=16).
module tb_arq_rx_gbn;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_seq;
   logic [31:0] in_data;
   logic        input_error;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        ack_valid;
   logic        ack_ready;
   logic [2:0]  ack_seq;
   logic [15:0] stat_err, stat_dup, stat_dlv;

   int checks = 0;
   int errors = 0;

   arq_rx_gbn #(.SEQ_W(3), .DATA_W(32), .ACK_REFRESH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_seq(in_seq), .in_data(in_data),
      .input_error(input_error),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_seq(ack_seq),
      .stat_err(stat_err), .stat_dup(stat_dup), .stat_dlv(stat_dlv)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_seq = '0; in_data = '0; input_error = 1'b0;
      out_ready = 1'b1; ack_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Present one frame for exactly one edge.
   task automatic send(input logic [2:0] s, input logic [31:0] d, input logic e);
      in_valid = 1'b1; in_seq = s; in_data = d; input_error = e;
      tick();
      in_valid = 1'b0; input_error = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_valid got %b want 0", ack_valid); end
      checks++; if (ack_seq !== 3'b111) begin errors++; $display("FAIL rst_ack_seq got %0d want 7", ack_seq); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      checks++; if ({stat_err, stat_dup, stat_dlv} !== 48'd0) begin errors++; $display("FAIL rst_stats got %h want 0", {stat_err, stat_dup, stat_dlv}); end
   endtask

   task automatic test_in_order();
      logic [2:0] s;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         s = 3'(i);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_in_ready[%0d] got %b want 1", i, in_ready); end
         send(s, 32'hA000_0000 + 32'(i), 1'b0);
         checks++; if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 + 32'(i)) begin
            errors++; $display("FAIL t1_deliver[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, 32'hA000_0000 + 32'(i)); end
         checks++; if (ack_valid !== 1'b1 || ack_seq !== s) begin
            errors++; $display("FAIL t1_ack[%0d] got v=%b s=%0d want v=1 s=%0d", i, ack_valid, ack_seq, s); end
      end
      tick();
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b0) begin
         errors++; $display("FAIL t1_drain got out_v=%b ack_v=%b want 0 0", out_valid, ack_valid); end
      // expected has wrapped to 2
      send(3'd2, 32'hA000_000A, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA000_000A || ack_seq !== 3'd2) begin
         errors++; $display("FAIL t1_expected2 got v=%b d=%h s=%0d want 1 a000000a 2", out_valid, out_data, ack_seq); end
`ifdef ARQ_RX_STATS_EN
      tick();
      checks++; if (stat_dlv !== 16'd11) begin errors++; $display("FAIL t1_stat_dlv got %0d want 11", stat_dlv); end
`endif
   endtask

   task automatic test_error_drop();
      do_reset();
      send(3'd0, 32'hB000_0000, 1'b0);
      send(3'd1, 32'hBEEF_0001, 1'b1);
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b0 || ack_seq !== 3'd0) begin
         errors++; $display("FAIL t2_err_drop got out_v=%b ack_v=%b s=%0d want 0 0 0", out_valid, ack_valid, ack_seq); end
      send(3'd1, 32'hB000_0001, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hB000_0001 || ack_seq !== 3'd1) begin
         errors++; $display("FAIL t2_seq1 got v=%b d=%h s=%0d want 1 b0000001 1", out_valid, out_data, ack_seq); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t2_single got %b want 0", out_valid); end
`ifdef ARQ_RX_STATS_EN
      checks++; if (stat_err !== 16'd1) begin errors++; $display("FAIL t2_stat_err got %0d want 1", stat_err); end
`else
      checks++; if (stat_err !== 16'd0) begin errors++; $display("FAIL t2_stat_off got %0d want 0", stat_err); end
`endif
   endtask

   task automatic test_dup_gap();
      do_reset();
      for (int i = 0; i < 3; i++) send(3'(i), 32'hC000_0000 + 32'(i), 1'b0);
      tick();
      send(3'd1, 32'hDEAD_0001, 1'b0);
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b1 || ack_seq !== 3'd2) begin
         errors++; $display("FAIL t3_dup got out_v=%b ack_v=%b s=%0d want 0 1 2", out_valid, ack_valid, ack_seq); end
`ifdef ARQ_RX_STATS_EN
      checks++; if (stat_dup !== 16'd1) begin errors++; $display("FAIL t3_stat_dup got %0d want 1", stat_dup); end
`endif
      tick();
      send(3'd4, 32'hDEAD_0004, 1'b0);
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b1 || ack_seq !== 3'd2) begin
         errors++; $display("FAIL t3_gap got out_v=%b ack_v=%b s=%0d want 0 1 2", out_valid, ack_valid, ack_seq); end
      send(3'd3, 32'hC000_0003, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hC000_0003 || ack_seq !== 3'd3) begin
         errors++; $display("FAIL t3_resume got v=%b d=%h s=%0d want 1 c0000003 3", out_valid, out_data, ack_seq); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      send(3'd0, 32'hD000_0000, 1'b0);
      in_valid = 1'b1; in_seq = 3'd1; in_data = 32'hD000_0001;
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hD000_0000) begin
            errors++; $display("FAIL t4_hold[%0d] got rdy=%b v=%b d=%h want 0 1 d0000000", i, in_ready, out_valid, out_data); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t4_release_rdy got %b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0001) begin
         errors++; $display("FAIL t4_seq1 got v=%b d=%h want 1 d0000001", out_valid, out_data); end
      in_seq = 3'd2; in_data = 32'hD000_0002;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hD000_0002 || ack_seq !== 3'd2) begin
         errors++; $display("FAIL t4_seq2 got v=%b d=%h s=%0d want 1 d0000002 2", out_valid, out_data, ack_seq); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_drain got %b want 0", out_valid); end
   endtask

   task automatic test_ack_coalesce_refresh();
      do_reset();
      ack_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(3'(i), 32'hE000_0000 + 32'(i), 1'b0);
         checks++; if (ack_valid !== 1'b1 || ack_seq !== 3'(i)) begin
            errors++; $display("FAIL t5_pend[%0d] got v=%b s=%0d want 1 %0d", i, ack_valid, ack_seq, i); end
      end
      tick();
      checks++; if (ack_valid !== 1'b1 || ack_seq !== 3'd2) begin
         errors++; $display("FAIL t5_stable got v=%b s=%0d want 1 2", ack_valid, ack_seq); end
      ack_ready = 1'b1;
      tick();
      ack_ready = 1'b0;
      checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL t5_handshake got %b want 0", ack_valid); end
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (k < 16) begin
            checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL t5_idle[%0d] got %b want 0", k, ack_valid); end
         end else begin
            checks++; if (ack_valid !== 1'b1 || ack_seq !== 3'd2) begin
               errors++; $display("FAIL t5_refresh got v=%b s=%0d want 1 2", ack_valid, ack_seq); end
         end
      end
      ack_ready = 1'b1;
      tick();
      checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL t5_refresh_hs got %b want 0", ack_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0; ack_ready = 1'b0;
      send(3'd0, 32'hF000_0000, 1'b0);
      checks++; if (out_valid !== 1'b1 || ack_valid !== 1'b1) begin
         errors++; $display("FAIL t6_pre got out_v=%b ack_v=%b want 1 1", out_valid, ack_valid); end
      in_valid = 1'b1; in_seq = 3'd1; in_data = 32'hF000_0001;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b0 || ack_seq !== 3'b111) begin
         errors++; $display("FAIL t6_async got out_v=%b ack_v=%b s=%0d want 0 0 7", out_valid, ack_valid, ack_seq); end
      in_valid = 1'b0;
      tick();
      rst = 1'b0; out_ready = 1'b1; ack_ready = 1'b1;
      tick();
      send(3'd1, 32'hF000_0011, 1'b0);
      checks++; if (out_valid !== 1'b0 || ack_valid !== 1'b0 || ack_seq !== 3'b111) begin
         errors++; $display("FAIL t6_seq1_drop got out_v=%b ack_v=%b s=%0d want 0 0 7", out_valid, ack_valid, ack_seq); end
      send(3'd0, 32'hF000_0010, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hF000_0010 || ack_seq !== 3'd0) begin
         errors++; $display("FAIL t6_seq0 got v=%b d=%h s=%0d want 1 f0000010 0", out_valid, out_data, ack_seq); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_error_drop();
      test_dup_gap();
      test_backpressure();
      test_ack_coalesce_refresh();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
